// File: rtl/i2c_reg16_slave.sv
// rtl/i2c_reg16_slave.sv - I2C target with 16-bit register pointer and 8-bit data
// Filters oversampled SCL/SDA, decodes bus framing and emits register write/read strobes.
module i2c_reg16_slave #(
  parameter logic [6:0] DEV_ADDR   = 7'h30,
  parameter int         FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        busy
);

  localparam int CW = $clog2(FILTER_LEN) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, DEVADDR, ACK_DEV, ADDR_HI, ACK_AH, ADDR_LO, ACK_AL,
    WDATA, ACK_WD, RDATA, RACK, IGNORE
  } state_t;

  // index 0 = SCL, index 1 = SDA
  logic [1:0]          sync1_q, sync2_q, filt_q, filt_d, prev_q;
  logic [1:0][CW-1:0]  fcnt_q, fcnt_d;

  state_t       state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shift_q, shift_d;
  logic [15:0]  ptr_q, ptr_d;
  logic         phase_q, phase_d;
  logic         rw_q, rw_d;
  logic         nack_q, nack_d;
  logic         sda_oe_q, sda_oe_d;
  logic         wr_en_q, wr_en_d;
  logic [15:0]  wr_addr_q, wr_addr_d;
  logic [7:0]   wr_data_q, wr_data_d;
  logic         rd_req_q, rd_req_d;
  logic [15:0]  rd_addr_q, rd_addr_d;
  logic         busy_q, busy_d;

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, last_bit;
  logic [7:0] byte_in;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = '0;
      filt_d[i] = filt_q[i];
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == CNT_MAX) filt_d[i] = sync2_q[i];
        else                      fcnt_d[i] = fcnt_q[i] + CW'(1);
      end
    end
  end

  assign scl_f     = filt_q[0];
  assign sda_f     = filt_q[1];
  assign scl_rise  = scl_f & ~prev_q[0];
  assign scl_fall  = ~scl_f & prev_q[0];
  assign start_det = scl_f & prev_q[0] & prev_q[1] & ~sda_f;
  assign stop_det  = scl_f & prev_q[0] & ~prev_q[1] & sda_f;
  assign byte_in   = {shift_q[6:0], sda_f};
  assign last_bit  = scl_rise && (bit_cnt_q == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      filt_q    <= 2'b11;
      prev_q    <= 2'b11;
      fcnt_q    <= '0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      phase_q   <= 1'b0;
      rw_q      <= 1'b0;
      nack_q    <= 1'b0;
      sda_oe_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= {sda_i, scl_i};
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      prev_q    <= filt_q;
      fcnt_q    <= fcnt_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      phase_q   <= phase_d;
      rw_q      <= rw_d;
      nack_q    <= nack_d;
      sda_oe_q  <= sda_oe_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = DEVADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        DEVADDR: if (last_bit) state_d = (byte_in[7:1] == DEV_ADDR) ? ACK_DEV : IGNORE;
        ACK_DEV: if (scl_fall && phase_q) state_d = rw_q ? RDATA : ADDR_HI;
        ADDR_HI: if (last_bit) state_d = ACK_AH;
        ACK_AH:  if (scl_fall && phase_q) state_d = ADDR_LO;
        ADDR_LO: if (last_bit) state_d = ACK_AL;
        ACK_AL:  if (scl_fall && phase_q) state_d = WDATA;
        WDATA:   if (last_bit) state_d = ACK_WD;
        ACK_WD:  if (scl_fall && phase_q) state_d = WDATA;
        RDATA:   if (last_bit) state_d = RACK;
        RACK:    if (scl_fall && phase_q) state_d = nack_q ? IGNORE : RDATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    phase_d   = phase_q;
    rw_d      = rw_q;
    nack_d    = nack_q;
    sda_oe_d  = sda_oe_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    busy_d    = (state_d != IDLE) && (state_d != IGNORE);

    // Fetch data arrives the clk after rd_req and immediately drives bit 7.
    if (rd_req_q) begin
      shift_d  = rd_data;
      sda_oe_d = ~rd_data[7];
    end

    if (start_det || stop_det) begin
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        DEVADDR, ADDR_HI, ADDR_LO, WDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = byte_in;
          end
          if (last_bit) begin
            phase_d = 1'b0;
            case (state_q)
              DEVADDR: rw_d = sda_f;
              ADDR_HI: ptr_d[15:8] = byte_in;
              ADDR_LO: ptr_d[7:0] = byte_in;
              default: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = byte_in;
                ptr_d     = ptr_q + 16'd1;
              end
            endcase
          end
        end
        ACK_DEV, ACK_AH, ACK_AL, ACK_WD: begin
          if (scl_fall) begin
            phase_d  = ~phase_q;
            sda_oe_d = ~phase_q;
            if (phase_q && state_q == ACK_DEV && rw_q) begin
              rd_req_d  = 1'b1;
              rd_addr_d = ptr_q;
              ptr_d     = ptr_q + 16'd1;
            end
          end
        end
        RDATA: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit) phase_d = 1'b0;
          if (scl_fall) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        RACK: begin
          if (scl_rise) nack_d = sda_f;
          if (scl_fall) begin
            phase_d  = ~phase_q;
            sda_oe_d = 1'b0;
            if (phase_q && !nack_q) begin
              rd_req_d  = 1'b1;
              rd_addr_d = ptr_q;
              ptr_d     = ptr_q + 16'd1;
            end
          end
        end
        default: begin
          bit_cnt_d = '0;
          phase_d   = 1'b0;
          sda_oe_d  = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe  = sda_oe_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;

endmodule
